// File: rtl/cpu_supervisor.sv
// cpu_supervisor: byte-stream command decoder (load/dump/run/halt) that owns the
// CPU control pins and the program RAM ports while the CPU is stopped.
module cpu_supervisor #(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_busy,
   output logic                  cpu_reset,
   output logic                  cpu_halt,
   output logic [addr_width-1:0] cpu_start,
   input  logic                  cpu_halted,
   output logic                  running,
   input  logic [addr_width-1:0] cpu_raddr,
   input  logic [addr_width-1:0] cpu_waddr,
   input  logic                  cpu_write,
   input  logic [7:0]            cpu_data_in,
   output logic [addr_width-1:0] mem_raddr,
   output logic [addr_width-1:0] mem_waddr,
   output logic                  mem_write,
   output logic [7:0]            mem_data_in,
   input  logic [7:0]            mem_data_out
);
   typedef enum logic [3:0] {
      IDLE, ARG, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_READ, DUMP_SEND, RUN_RST, HALT_WAIT, REPLY
   } state_t;

   localparam logic [7:0] OP_L = 8'h4C, OP_D = 8'h44, OP_R = 8'h52, OP_H = 8'h48;
   localparam logic [7:0] CH_OK = 8'h2E, CH_Q = 8'h3F, CH_BANG = 8'h21, CH_X = 8'h58;

   state_t                state_q, state_d;
   logic [7:0]            op_q, op_d, reply_q, reply_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [23:0]           args_q, args_d;
   logic [15:0]           len_q, len_d, arg_len;
   logic [addr_width-1:0] ptr_q, ptr_d, raddr_q, raddr_d, waddr_q, waddr_d;
   logic [addr_width-1:0] cpu_start_q, cpu_start_d, arg_addr;
   logic                  sup_write_q, sup_write_d, cpu_reset_q, cpu_reset_d, cpu_halt_q, cpu_halt_d;
   logic                  running_q, running_d, pending_x_q, pending_x_d, last_arg;

   assign cpu_reset   = cpu_reset_q;
   assign cpu_halt    = cpu_halt_q;
   assign cpu_start   = cpu_start_q;
   assign running     = running_q;
   assign mem_raddr   = running_q ? cpu_raddr : raddr_q;
   assign mem_waddr   = running_q ? cpu_waddr : waddr_q;
   assign mem_data_in = running_q ? cpu_data_in : wdata_q;
   assign mem_write   = (running_q & cpu_write) | sup_write_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      args_d      = args_q;
      len_d       = len_q;
      ptr_d       = ptr_q;
      raddr_d     = raddr_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      reply_d     = reply_q;
      sup_write_d = 1'b0;
      cpu_reset_d = cpu_reset_q;
      cpu_halt_d  = cpu_halt_q;
      cpu_start_d = cpu_start_q;
      running_d   = running_q;
      pending_x_d = pending_x_q;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      last_arg    = rx_valid && cnt_q == (op_q == OP_R ? 2'd1 : 2'd3);
      arg_addr    = addr_width'(op_q == OP_R ? {args_q[7:0], rx_data} : args_q[23:8]);
      arg_len     = {args_q[7:0], rx_data};
      case (state_q)
         IDLE:
            if (pending_x_q && !tx_busy) begin
               tx_valid    = 1'b1;
               tx_data     = CH_X;
               pending_x_d = 1'b0;
            end else if (rx_valid) begin
               op_d  = rx_data;
               cnt_d = 2'd0;
               if (rx_data == OP_L || rx_data == OP_D || rx_data == OP_R) state_d = ARG;
               else if (rx_data == OP_H && running_q) begin
                  state_d    = HALT_WAIT;
                  cpu_halt_d = 1'b1;
               end else begin
                  state_d = REPLY;
                  reply_d = rx_data == OP_H ? CH_OK : CH_Q;
               end
            end
         ARG:
            if (rx_valid) begin
               args_d = {args_q[15:0], rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (last_arg && op_q == OP_R) begin
                  cpu_start_d = arg_addr;
                  cpu_reset_d = 1'b1;
                  running_d   = 1'b0;
                  cnt_d       = 2'd0;
                  state_d     = RUN_RST;
               end else if (last_arg) begin
                  len_d   = arg_len;
                  ptr_d   = arg_addr;
                  raddr_d = arg_addr;
                  reply_d = running_q ? CH_BANG : CH_OK;
                  state_d = arg_len == 16'd0 ? REPLY : op_q == OP_L ? LOAD : running_q ? REPLY : DUMP_ADDR;
               end
            end
         LOAD:
            if (rx_valid) begin
               len_d = len_q - 16'd1;
               ptr_d = ptr_q + 1'b1;
               // a load issued while the CPU ran is drained without touching memory
               if (reply_q == CH_OK) begin
                  sup_write_d = 1'b1;
                  waddr_d     = ptr_q;
                  wdata_d     = rx_data;
               end
               if (len_q == 16'd1) state_d = REPLY;
            end
         DUMP_ADDR: state_d = DUMP_WAIT;
         DUMP_WAIT: state_d = DUMP_READ;
         DUMP_READ: begin
            rdata_d = mem_data_out;
            state_d = DUMP_SEND;
         end
         DUMP_SEND:
            if (!tx_busy) begin
               tx_valid = 1'b1;
               tx_data  = rdata_q;
               len_d    = len_q - 16'd1;
               raddr_d  = raddr_q + 1'b1;
               state_d  = len_q == 16'd1 ? REPLY : DUMP_ADDR;
            end
         RUN_RST: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd1) begin
               cpu_reset_d = 1'b0;
               running_d   = 1'b1;
               reply_d     = CH_OK;
               state_d     = REPLY;
            end
         end
         HALT_WAIT:
            if (cpu_halted) begin
               running_d   = 1'b0;
               cpu_reset_d = 1'b1;
               cpu_halt_d  = 1'b0;
               reply_d     = CH_OK;
               state_d     = REPLY;
            end
         REPLY:
            if (!tx_busy) begin
               tx_valid = 1'b1;
               tx_data  = reply_q;
               state_d  = IDLE;
            end
         default: state_d = IDLE;
      endcase
      if (running_q && cpu_halted && state_q != HALT_WAIT) begin
         running_d   = 1'b0;
         cpu_reset_d = 1'b1;
         pending_x_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         args_q      <= '0;
         len_q       <= '0;
         ptr_q       <= '0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         reply_q     <= '0;
         sup_write_q <= 1'b0;
         cpu_reset_q <= 1'b1;
         cpu_halt_q  <= 1'b0;
         cpu_start_q <= '0;
         running_q   <= 1'b0;
         pending_x_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         args_q      <= args_d;
         len_q       <= len_d;
         ptr_q       <= ptr_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         reply_q     <= reply_d;
         sup_write_q <= sup_write_d;
         cpu_reset_q <= cpu_reset_d;
         cpu_halt_q  <= cpu_halt_d;
         cpu_start_q <= cpu_start_d;
         running_q   <= running_d;
         pending_x_q <= pending_x_d;
      end
   end
endmodule
